// File: rtl/row_adc_pkg.sv
// Shared types, default sizes and width helpers for the row ADC frame sequencer.
package row_adc_pkg;

  localparam int DEF_NUM_PIXELS = 50;
  localparam int DEF_CNT_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_RST,
    S_RAMP,
    S_SETTLE,
    S_CAPTURE,
    S_READOUT
  } seq_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/row_readout_buffer.sv
// Frame snapshot of the row ADC results plus the valid/ready pixel serializer.
module row_readout_buffer
  import row_adc_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int IDX_W      = idx_w(NUM_PIXELS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load,
  input  logic                        active,
  input  logic [NUM_PIXELS*CNT_W-1:0] adc_values,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [CNT_W-1:0]            out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last
);

  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_PIXELS - 1);

  logic [NUM_PIXELS*CNT_W-1:0] snapshot;
  logic [IDX_W-1:0]            ptr;

  // NOTE: the snapshot is wide but still reset, so a reset mid-frame can never leak stale pixel data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot <= '0;
      ptr      <= '0;
    end else if (load) begin
      snapshot <= adc_values;
      ptr      <= '0;
    end else if (active && out_ready) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  assign out_valid = active;
  assign out_last  = active && (ptr == PTR_LAST);
  assign out_index = active ? ptr : '0;
  assign out_data  = active ? snapshot[ptr*CNT_W +: CNT_W] : '0;

endmodule

// File: rtl/row_adc_sequencer.sv
// Frame controller for the single-slope row ADC: reset, ramp, settle, capture, stream out.
module row_adc_sequencer
  import row_adc_pkg::*;
#(
  parameter int NUM_PIXELS    = DEF_NUM_PIXELS,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_PIXELS*CNT_W-1:0] adc_values,
  output logic                        adc_rst,
  output logic                        ramp_en,
  output logic [CNT_W-1:0]            ramp_code,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            out_data,
  output logic [idx_w(NUM_PIXELS)-1:0] out_index,
  output logic                        out_last,
  output logic                        done,
  output logic [15:0]                 frame_count
);

  localparam int IDX_W = idx_w(NUM_PIXELS);
  // One phase timer serves reset, ramp and settle; sized for the longest of them.
  localparam int TMR_W = max_int(CNT_W, max_int(idx_w(RESET_CYCLES), idx_w(SETTLE_CYCLES)));

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RAMP_LAST   = TMR_W'({CNT_W{1'b1}});

  seq_state_e       state, state_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic             frame_done;

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ROW_RST;
          tmr_next   = '0;
        end
      end
      S_ROW_RST: begin
        if (tmr == RST_LAST) begin
          state_next = S_RAMP;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr + 1'b1;
        end
      end
      S_RAMP: begin
        if (tmr == RAMP_LAST) begin
          state_next = S_SETTLE;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr + 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr == SETTLE_LAST) begin
          state_next = S_CAPTURE;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr + 1'b1;
        end
      end
      S_CAPTURE: state_next = S_READOUT;
      S_READOUT: begin
        if (out_valid && out_ready && out_last) begin
          state_next = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides start and a final handshake landing on the same edge.
    if (abort) begin
      state_next = S_IDLE;
      tmr_next   = '0;
      frame_done = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tmr         <= '0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      tmr   <= tmr_next;
      done  <= frame_done;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

  assign adc_rst   = (state == S_ROW_RST);
  assign ramp_en   = (state == S_RAMP);
  assign ramp_code = ramp_en ? tmr[CNT_W-1:0] : '0;
  assign busy      = (state != S_IDLE);

  row_readout_buffer #(
    .NUM_PIXELS(NUM_PIXELS),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_readout (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (state == S_CAPTURE),
    .active    (state == S_READOUT),
    .adc_values(adc_values),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

endmodule
